// File: rtl/proc_pkg.sv
// Shared core types for the memory access pipeline: word/register sizing and the in-flight
// entry record carried through the slots.
package proc_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_BITS  = $clog2(NUM_REGS);

  typedef struct packed {
    logic                 valid;
    logic                 read;
    logic                 writeback;
    logic [REG_BITS-1:0]  rd;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
  } mem_entry_t;

endpackage

// File: rtl/mem_slot_lookup.sv
// Priority search of the in-flight entries (index 0 youngest) for the youngest writeback to
// rd_i; a hit is reported only when that youngest match is a non-load.
module mem_slot_lookup
  import proc_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  mem_entry_t [Depth-1:0] entries_i,
  input  logic [REG_BITS-1:0]    rd_i,
  output logic                   hit_o,
  output logic [WORD_SIZE-1:0]   data_o
);

  logic unused_addr;

  always_comb begin
    hit_o       = 1'b0;
    data_o      = '0;
    unused_addr = 1'b0;
    // Walk oldest to youngest so the youngest match overwrites the rest.
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      unused_addr = unused_addr ^ (^entries_i[k].addr);
      if (entries_i[k].valid && entries_i[k].writeback && (entries_i[k].rd == rd_i)) begin
        hit_o  = ~entries_i[k].read;
        data_o = entries_i[k].read ? '0 : entries_i[k].data;
      end
    end
  end

endmodule

// File: rtl/mem_access_pipe.sv
// Data-memory access pipeline between Execute and Writeback with DataDone stalling and a
// pending-writeback mask. Define MEM_FWD_EN to add the result-forwarding ports.
module mem_access_pipe
  import proc_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_read,
  input  logic                   in_write,
  input  logic [WORD_SIZE-1:0]   in_addr,
  input  logic [WORD_SIZE-1:0]   in_wdata,
  input  logic [WORD_SIZE-1:0]   in_result,
  input  logic [REG_BITS-1:0]    in_rd,
  input  logic                   in_writeback,
  output logic [WORD_SIZE-1:0]   DataAddr,
  output logic [WORD_SIZE-1:0]   DataOut,
  output logic                   ReadData,
  output logic                   WriteData,
  input  logic [WORD_SIZE-1:0]   DataIn,
  input  logic                   DataDone,
  output logic                   out_valid,
  output logic [REG_BITS-1:0]    out_rd,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic                   out_writeback,
  output logic [NUM_REGS-1:0]    busy_mask,
`ifdef MEM_FWD_EN
  input  logic [REG_BITS-1:0]    fwd_reg,
  output logic                   fwd_hit,
  output logic [WORD_SIZE-1:0]   fwd_data,
`endif
  output logic [$clog2(MEM_LATENCY+1)-1:0] pending_cnt
);

  localparam int unsigned NumSlots = (MEM_LATENCY > 1) ? MEM_LATENCY - 1 : 1;
  localparam int unsigned CntW     = $clog2(MEM_LATENCY + 1);
`ifdef MEM_FWD_EN
  localparam bit BusyLoadsOnly = 1'b1;
`else
  localparam bit BusyLoadsOnly = 1'b0;
`endif

  mem_entry_t                   slots_q [NumSlots];
  mem_entry_t                   out_q;
  mem_entry_t                   in_entry;
  mem_entry_t                   tail;
  mem_entry_t                   tail_cap;
  mem_entry_t [MEM_LATENCY-1:0] flight;

  assign in_ready  = DataDone;
  assign ReadData  = in_valid & in_read & ~in_write;
  assign WriteData = in_valid & in_write;
  assign DataAddr  = in_addr;
  assign DataOut   = WriteData ? in_wdata : '0;

  // Read+write together is treated as a store; stores never write back.
  always_comb begin
    in_entry = '0;
    if (in_valid) begin
      in_entry.valid     = 1'b1;
      in_entry.read      = in_read & ~in_write;
      in_entry.writeback = in_writeback & ~in_write;
      in_entry.rd        = in_rd;
      in_entry.addr      = in_addr;
      in_entry.data      = in_result;
    end
  end

  // The request cycle itself is the first latency stage, so L-1 slot registers feed out_q.
  assign tail = (MEM_LATENCY > 1) ? slots_q[NumSlots-1] : in_entry;

  always_comb begin
    tail_cap = tail;
    if (tail.read) tail_cap.data = DataIn;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < int'(NumSlots); k++) slots_q[k] <= '0;
      out_q <= '0;
    end else if (DataDone) begin
      slots_q[0] <= in_entry;
      for (int k = 1; k < int'(NumSlots); k++) slots_q[k] <= slots_q[k-1];
      out_q <= tail_cap;
    end else begin
      out_q <= '0;
    end
  end

  assign out_valid     = out_q.valid;
  assign out_rd        = out_q.rd;
  assign out_data      = out_q.data;
  assign out_writeback = out_q.writeback;

  always_comb begin
    for (int k = 0; k < int'(MEM_LATENCY) - 1; k++) flight[k] = slots_q[k];
    flight[MEM_LATENCY-1] = out_q;
  end

  always_comb begin
    busy_mask   = '0;
    pending_cnt = '0;
    for (int k = 0; k < int'(MEM_LATENCY); k++) begin
      if (flight[k].valid) begin
        pending_cnt = pending_cnt + CntW'(1);
        if (flight[k].writeback && (!BusyLoadsOnly || flight[k].read)) begin
          busy_mask[flight[k].rd] = 1'b1;
        end
      end
    end
  end

  logic                 lookup_hit;
  logic [WORD_SIZE-1:0] lookup_data;
  logic [REG_BITS-1:0]  lookup_rd;
  logic                 unused_bits;

`ifdef MEM_FWD_EN
  assign lookup_rd   = fwd_reg;
  assign fwd_hit     = lookup_hit;
  assign fwd_data    = lookup_data;
  assign unused_bits = ^{out_q.addr, out_q.read};
`else
  // Lookup stays instantiated so the hierarchy is the same in both builds.
  assign lookup_rd   = '0;
  assign unused_bits = ^{out_q.addr, out_q.read, lookup_hit, lookup_data};
`endif

  mem_slot_lookup #(
    .Depth(MEM_LATENCY)
  ) u_lookup (
    .entries_i(flight),
    .rd_i     (lookup_rd),
    .hit_o    (lookup_hit),
    .data_o   (lookup_data)
  );

endmodule
